debug_bus_gate: RTL

- Drives the `available` and `intercept` controls of the arilla bus.
- Decides when the rv_core may launch bus transactions and when the debug side owns the bus.
- Sits between the debug request logic and the core/memory bus. It replaces the constant tie-offs used in standalone simulation.
- Implements halt, resume and single-step. Halt is graceful: it drains in-flight core transactions first.

---
 rtl/debug_bus_gate.sv | 135 +++++++++++++
 1 files changed

// File: rtl/debug_bus_gate.sv
// Debug bus gate: drives the arilla bus available/intercept controls for halt, resume and single-step.
// All outputs are registered (one-cycle response to requests); halt drains in-flight core transactions first.
module debug_bus_gate #(
  parameter int unsigned MaxOutstanding = 1,
  parameter int unsigned HaltTimeout    = 64,
  parameter bit          HaltOnReset    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       halt_req,
  input  logic       resume_req,
  input  logic       step_req,
  input  logic       core_req,
  input  logic       core_done,
  output logic       available,
  output logic       intercept,
  output logic       halted,
  output logic       halt_timeout,
  output logic [3:0] outstanding
);

  localparam logic [3:0]  MAX_OUT = 4'(MaxOutstanding);
  localparam logic [15:0] TO_LIM  = 16'(HaltTimeout);

  typedef enum logic [2:0] {
    ST_RUNNING,
    ST_HALT_PENDING,
    ST_HALTED,
    ST_STEP_ISSUE,
    ST_STEP_DRAIN
  } state_e;

  localparam state_e RESET_STATE = HaltOnReset ? ST_HALTED : ST_RUNNING;

  state_e      state_q, state_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        resume_pend_q, resume_pend_d;
  logic        timeout_d;
  logic [3:0]  out_d;
  logic        accept, retire, drained, resume_taken;
  logic        avail_d;

  always_comb begin
    accept        = core_req & available;
    // A completion with nothing in flight is spurious and must not wrap the count.
    retire        = core_done & (outstanding != 4'd0);
    out_d         = outstanding + {3'b000, accept} - {3'b000, retire};
    drained       = (out_d == 4'd0);
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    timeout_d     = halt_timeout;
    resume_pend_d = resume_pend_q;
    resume_taken  = 1'b0;

    case (state_q)
      ST_RUNNING: begin
        if (halt_req) state_d = ST_HALT_PENDING;
      end
      ST_HALT_PENDING: begin
        if (resume_req) begin
          state_d      = ST_RUNNING;
          resume_taken = 1'b1;
        end else if (drained) begin
          state_d = ST_HALTED;
        end else begin
          if (to_cnt_q != TO_LIM) to_cnt_d = to_cnt_q + 16'd1;
          if (to_cnt_d == TO_LIM) timeout_d = 1'b1;
        end
      end
      ST_HALTED: begin
        if (resume_req) begin
          state_d      = ST_RUNNING;
          resume_taken = 1'b1;
        end else if (step_req) begin
          state_d = ST_STEP_ISSUE;
        end
      end
      ST_STEP_ISSUE: begin
        if (resume_req) begin
          state_d      = ST_RUNNING;
          resume_taken = 1'b1;
        end else if (halt_req) begin
          state_d = ST_HALT_PENDING;
        end else if (accept) begin
          state_d = ST_STEP_DRAIN;
        end
      end
      ST_STEP_DRAIN: begin
        // A resume seen mid-drain is remembered and honoured once the step completes.
        if (drained) begin
          resume_pend_d = 1'b0;
          if (resume_req || resume_pend_q) begin
            state_d      = ST_RUNNING;
            resume_taken = 1'b1;
          end else begin
            state_d = ST_HALTED;
          end
        end else if (resume_req) begin
          resume_pend_d = 1'b1;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    if (resume_taken) begin
      to_cnt_d  = 16'd0;
      timeout_d = 1'b0;
    end

    avail_d = ((state_d == ST_RUNNING) || (state_d == ST_STEP_ISSUE)) && (out_d < MAX_OUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      to_cnt_q      <= 16'd0;
      resume_pend_q <= 1'b0;
      halt_timeout  <= 1'b0;
      outstanding   <= 4'd0;
      available     <= ~HaltOnReset;
      intercept     <= HaltOnReset;
      halted        <= HaltOnReset;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      resume_pend_q <= resume_pend_d;
      halt_timeout  <= timeout_d;
      outstanding   <= out_d;
      available     <= avail_d;
      intercept     <= (state_d == ST_HALTED);
      halted        <= (state_d == ST_HALTED);
    end
  end

endmodule
